// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and default sizes for the gated frequency meter
//
// Contents:
//   state_t          FSM encoding, IDLE=0, GATE=1
//   DEF_GATE_CYCLES  default window length in CLK cycles (1 s at 50 MHz)
//   DEF_CNT_W        default width of the edge counter / frecuencia
//   DEF_PER_W        default width of periodo
//   gate_cnt_w()     width needed to count 0 .. cycles-1, never below 1
package freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  localparam int DEF_GATE_CYCLES = 50_000_000;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_PER_W       = 32;

  function automatic int gate_cnt_w(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// rtl/edge_sync.sv - synchronizes an asynchronous input and flags its rising edges
//
// Ports:
//   CLK       system clock, rising edge
//   Reset     synchronous, active-high; clears all three flops
//   async_in  signal asynchronous to CLK
//   pulse     one-cycle pulse per synchronized rising edge of async_in
module edge_sync (
  input  logic CLK,
  input  logic Reset,
  input  logic async_in,
  output logic pulse
);

  // s1/s2 form the metastability guard; s3 is the one-cycle-old copy of s2
  // used only for edge detection, so s1 is never looked at by logic.
  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency meter: counts input edges over a fixed CLK window
//
// Optional feature: define FREQ_METER_PERIOD_EN to build the period measurement
// (periodo / periodo_valido); otherwise both outputs are tied to 0.
//
// Parameters:
//   GATE_CYCLES  window length in CLK cycles (>= 2)
//   CNT_W        width of edge counter and frecuencia
//   PER_W        width of periodo
// Ports:
//   CLK             system clock, rising edge
//   Reset           synchronous, active-high
//   senal           signal under measurement, asynchronous to CLK
//   start           one-cycle request to start a window, honoured only in IDLE
//   continuo        re-arm after each window, sampled on the last gate cycle
//   frecuencia      edge count of the last completed window
//   valido          one-cycle pulse when frecuencia updates
//   saturado        count of that window clipped at all-ones
//   ocupado         high while a window is open
//   periodo         CLK cycles between the last two input edges
//   periodo_valido  one-cycle pulse when periodo updates
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int PER_W       = DEF_PER_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             senal,
  input  logic             start,
  input  logic             continuo,
  output logic [CNT_W-1:0] frecuencia,
  output logic             valido,
  output logic             saturado,
  output logic             ocupado,
  output logic [PER_W-1:0] periodo,
  output logic             periodo_valido
);

  localparam int               GW        = gate_cnt_w(GATE_CYCLES);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state;
  state_t            state_nx;
  logic [GW-1:0]     gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              ovf;
  logic              edge_p;
  logic              last_gate;
  logic              clip_now;

  edge_sync u_edge_sync (
    .CLK      (CLK),
    .Reset    (Reset),
    .async_in (senal),
    .pulse    (edge_p)
  );

  assign last_gate = (state == GATE) && (gate_cnt == GATE_LAST);
  // An edge arriving while the counter already sits at all-ones is a lost edge.
  assign clip_now  = edge_p && (edge_cnt == CNT_MAX);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ocupado  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = GATE;
        end
      end
      GATE: begin
        ocupado = 1'b1;
        if (last_gate) begin
          // Re-entering GATE directly keeps continuous mode free of dead cycles.
          state_nx = continuo ? GATE : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf        <= 1'b0;
      frecuencia <= '0;
      saturado   <= 1'b0;
      valido     <= 1'b0;
    end else begin
      valido <= 1'b0;
      if (state == GATE) begin
        if (last_gate) begin
          // The edge seen in the last gate cycle still belongs to this window.
          frecuencia <= clip_now ? CNT_MAX : (edge_cnt + CNT_W'(edge_p));
          saturado   <= ovf | clip_now;
          valido     <= 1'b1;
          gate_cnt   <= '0;
          edge_cnt   <= '0;
          ovf        <= 1'b0;
        end else begin
          gate_cnt <= gate_cnt + GW'(1);
          if (clip_now) begin
            ovf <= 1'b1;
          end else if (edge_p) begin
            edge_cnt <= edge_cnt + CNT_W'(1);
          end
        end
      end else begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic [PER_W-1:0] per_cnt;
  logic             per_armed;

  // Free-running, independent of the gate FSM. per_cnt counts the cycles
  // since the previous edge, so the edge cycle itself adds one.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      per_cnt        <= '0;
      per_armed      <= 1'b0;
      periodo        <= '0;
      periodo_valido <= 1'b0;
    end else begin
      periodo_valido <= 1'b0;
      if (edge_p) begin
        if (per_armed) begin
          periodo        <= (per_cnt == PER_MAX) ? PER_MAX : (per_cnt + PER_W'(1));
          periodo_valido <= 1'b1;
        end
        per_armed <= 1'b1;
        per_cnt   <= '0;
      end else if (per_cnt != PER_MAX) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
    end
  end
`else
  assign periodo        = '0;
  assign periodo_valido = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - directed self-checking bench for freq_meter (GATE_CYCLES=100)
module tb_freq_meter;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        senal = 1'b0;
  logic        start = 1'b0;
  logic        continuo = 1'b0;

  logic [31:0] frecuencia;
  logic        valido;
  logic        saturado;
  logic        ocupado;
  logic [31:0] periodo;
  logic        periodo_valido;

  logic [3:0]  f4;
  logic        v4;
  logic        s4;
  logic        o4;
  logic [7:0]  p4;
  logic        pv4;

  int checks = 0;
  int errors = 0;
  int per = 2;
  int ph = 0;

  always #5 CLK = ~CLK;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(32), .PER_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .senal(senal), .start(start), .continuo(continuo),
    .frecuencia(frecuencia), .valido(valido), .saturado(saturado), .ocupado(ocupado),
    .periodo(periodo), .periodo_valido(periodo_valido)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .PER_W(8)) dut4 (
    .CLK(CLK), .Reset(Reset), .senal(senal), .start(start), .continuo(continuo),
    .frecuencia(f4), .valido(v4), .saturado(s4), .ocupado(o4),
    .periodo(p4), .periodo_valido(pv4)
  );

  // Square wave of 'per' CLK cycles, changing on the falling edge.
  always @(negedge CLK) begin
    if (per < 2) begin
      senal = 1'b0;
      ph = 0;
    end else begin
      if (ph >= per - 1) ph = 0;
      else ph = ph + 1;
      senal = (ph < per / 2);
    end
  end

  task automatic pulse_start();
    @(posedge CLK); #1; start = 1'b1;
    @(posedge CLK); #1; start = 1'b0;
  endtask

  task automatic settle(input int p);
    per = p;
    repeat (40) @(posedge CLK);
    #1;
  endtask

  // n counts CLK edges since the edge that sampled start.
  task automatic wait_valido(input int budget, inout int n, output bit ok);
    ok = 1'b0;
    while (n <= budget) begin
      @(negedge CLK);
      if (valido) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    per = 2;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if ({valido, ocupado, saturado, periodo_valido} !== 4'b0000 || frecuencia !== 32'd0 || periodo !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got v=%b o=%b s=%b pv=%b f=%0d p=%0d, expected all 0",
                 i, valido, ocupado, saturado, periodo_valido, frecuencia, periodo);
      end
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    start = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (valido || ocupado) seen++;
      end
      checks++;
      if (seen !== 0) begin
        errors++;
        $display("FAIL reset_start_ignored: got %0d busy/valid cycles, expected 0", seen);
      end
    end
  endtask

  task automatic test_one_shot();
    int n;
    bit ok;
    continuo = 1'b0;
    settle(10);
    pulse_start();
    checks++;
    if (ocupado !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_busy: got %b expected 1", ocupado);
    end
    n = 0;
    wait_valido(110, n, ok);
    checks++;
    if (!ok || n !== 100) begin
      errors++;
      $display("FAIL oneshot_latency: got ok=%0d n=%0d expected n=100", ok, n);
    end
    checks++;
    if (frecuencia !== 32'd10 || saturado !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_value: got f=%0d s=%b expected f=10 s=0", frecuencia, saturado);
    end
    checks++;
    if (ocupado !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_idle: got ocupado=%b expected 0", ocupado);
    end
    checks++;
    if (v4 !== 1'b1 || f4 !== 4'd10 || s4 !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_narrow: got v=%b f=%0d s=%b expected v=1 f=10 s=0", v4, f4, s4);
    end
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (frecuencia !== 32'd10 || valido !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_hold: got f=%0d v=%b expected f=10 v=0", frecuencia, valido);
    end
  endtask

  task automatic test_continuous();
    int n;
    bit ok;
    settle(20);
    continuo = 1'b1;
    pulse_start();
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      wait_valido(k * 100 + 10, n, ok);
      checks++;
      if (!ok || n !== k * 100) begin
        errors++;
        $display("FAIL cont_latency[%0d]: got ok=%0d n=%0d expected n=%0d", k, ok, n, k * 100);
      end
      checks++;
      if (frecuencia !== 32'd5 || f4 !== 4'd5) begin
        errors++;
        $display("FAIL cont_value[%0d]: got f=%0d f4=%0d expected 5", k, frecuencia, f4);
      end
      checks++;
      if (ocupado !== (k < 4)) begin
        errors++;
        $display("FAIL cont_busy[%0d]: got %b expected %b", k, ocupado, (k < 4));
      end
      if (k == 3) continuo = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic test_saturation();
    int n;
    bit ok;
    settle(2);
    pulse_start();
    n = 0;
    wait_valido(110, n, ok);
    checks++;
    if (!ok || f4 !== 4'd15 || s4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_clip: got ok=%0d f4=%0d s4=%b expected f4=15 s4=1", ok, f4, s4);
    end
    checks++;
    if (frecuencia !== 32'd50 || saturado !== 1'b0) begin
      errors++;
      $display("FAIL sat_wide: got f=%0d s=%b expected f=50 s=0", frecuencia, saturado);
    end
    settle(10);
    pulse_start();
    n = 0;
    wait_valido(110, n, ok);
    checks++;
    if (!ok || f4 !== 4'd10 || s4 !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got ok=%0d f4=%0d s4=%b expected f4=10 s4=0", ok, f4, s4);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit ok;
    int seen;
    settle(10);
    pulse_start();
    repeat (50) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    checks++;
    if (ocupado !== 1'b0 || valido !== 1'b0 || frecuencia !== 32'd0 || saturado !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got o=%b v=%b f=%0d s=%b expected all 0", ocupado, valido, frecuencia, saturado);
    end
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if (valido || ocupado) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midreset_quiet: got %0d busy/valid cycles expected 0", seen);
    end
    pulse_start();
    n = 0;
    wait_valido(110, n, ok);
    checks++;
    if (!ok || n !== 100 || frecuencia !== 32'd10) begin
      errors++;
      $display("FAIL midreset_restart: got ok=%0d n=%0d f=%0d expected n=100 f=10", ok, n, frecuencia);
    end
  endtask

  task automatic test_period();
    int pulses;
    int bad;
    settle(7);
    pulses = 0;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge CLK);
      if (periodo_valido) begin
        pulses++;
        if (periodo !== 32'd7) bad++;
      end
    end
`ifdef FREQ_METER_PERIOD_EN
    checks++;
    if (pulses !== 10 || bad !== 0 || periodo !== 32'd7) begin
      errors++;
      $display("FAIL period_value: got pulses=%0d bad=%0d p=%0d expected pulses=10 bad=0 p=7", pulses, bad, periodo);
    end
`else
    checks++;
    if (pulses !== 0 || periodo !== 32'd0) begin
      errors++;
      $display("FAIL period_disabled: got pulses=%0d p=%0d expected 0 0", pulses, periodo);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_shot();
    test_continuous();
    test_saturation();
    test_mid_reset();
    test_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
